// File: rtl/date_counter_if.sv
//==============================================================================
// Module      : date_counter_if
// Description : Load/advance request and date output bundle of date_counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface date_counter_if;
  logic        load;
  logic [5:0]  loadDay;
  logic [3:0]  loadMonth;
  logic [10:0] loadYear;
  logic        advance;
  logic [5:0]  dayOfMonth;
  logic [3:0]  month;
  logic [10:0] year;
  logic        loadErr;
  logic        newYear;
  logic        yearOvf;

  modport master (
    output load, loadDay, loadMonth, loadYear, advance,
    input  dayOfMonth, month, year, loadErr, newYear, yearOvf
  );

  modport slave (
    input  load, loadDay, loadMonth, loadYear, advance,
    output dayOfMonth, month, year, loadErr, newYear, yearOvf
  );
endinterface

`default_nettype wire

// File: rtl/date_counter.sv
//==============================================================================
// Module      : date_counter
// Description : Registered calendar date that advances one day per enabled
//               cycle, with checked synchronous load and year wrap pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module date_counter #(
  parameter logic        CAL_SELECT = 1'b0,
  parameter logic [10:0] RESET_YEAR = 11'd1970
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  date_counter_if.slave  bus
);

  localparam logic [10:0] MAX_YEAR = 11'd2047;
  localparam logic [3:0]  DEC      = 4'd12;

  // y%100 and y%400 over 0..2047 reduce to matching a handful of constants
  function automatic logic is_leap(input logic [10:0] y);
    logic div100;
    logic div400;
    div100 = 1'b0;
    div400 = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (y == 11'(k * 100)) begin
        div100 = 1'b1;
        if ((k % 4) == 0) div400 = 1'b1;
      end
    end
    if (CAL_SELECT) is_leap = (y[1:0] == 2'b00);
    else            is_leap = (y[1:0] == 2'b00) && (!div100 || div400);
  endfunction

  function automatic logic [5:0] month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: month_len = 6'd30;
      4'd2:                    month_len = leap ? 6'd29 : 6'd28;
      default:                 month_len = 6'd31;
    endcase
  endfunction

  logic [5:0]  day_q, day_d;
  logic [3:0]  month_q, month_d;
  logic [10:0] year_q, year_d;
  logic        load_err_q, load_err_d;
  logic        new_year_q, new_year_d;
  logic        year_ovf_q, year_ovf_d;

  logic [5:0]  w_load_len;
  logic [5:0]  w_cur_len;
  logic        w_load_ok;

  always_comb begin
    day_d      = day_q;
    month_d    = month_q;
    year_d     = year_q;
    load_err_d = 1'b0;
    new_year_d = 1'b0;
    year_ovf_d = 1'b0;

    w_load_len = month_len(bus.loadMonth, is_leap(bus.loadYear));
    w_cur_len  = month_len(month_q, is_leap(year_q));
    w_load_ok  = (bus.loadMonth >= 4'd1) && (bus.loadMonth <= DEC) &&
                 (bus.loadDay >= 6'd1) && (bus.loadDay <= w_load_len);

    if (bus.load) begin
      if (w_load_ok) begin
        day_d   = bus.loadDay;
        month_d = bus.loadMonth;
        year_d  = bus.loadYear;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.advance) begin
      if (day_q < w_cur_len) begin
        day_d = day_q + 6'd1;
      end else if (month_q < DEC) begin
        day_d   = 6'd1;
        month_d = month_q + 4'd1;
      end else begin
        day_d      = 6'd1;
        month_d    = 4'd1;
        new_year_d = 1'b1;
        if (year_q == MAX_YEAR) begin
          year_d     = 11'd0;
          year_ovf_d = 1'b1;
        end else begin
          year_d = year_q + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      day_q      <= 6'd1;
      month_q    <= 4'd1;
      year_q     <= RESET_YEAR;
      load_err_q <= 1'b0;
      new_year_q <= 1'b0;
      year_ovf_q <= 1'b0;
    end else begin
      day_q      <= day_d;
      month_q    <= month_d;
      year_q     <= year_d;
      load_err_q <= load_err_d;
      new_year_q <= new_year_d;
      year_ovf_q <= year_ovf_d;
    end
  end

  assign bus.dayOfMonth = day_q;
  assign bus.month      = month_q;
  assign bus.year       = year_q;
  assign bus.loadErr    = load_err_q;
  assign bus.newYear    = new_year_q;
  assign bus.yearOvf    = year_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_date_counter.sv
//==============================================================================
// Module      : tb_date_counter
// Description : Directed vector bench for date_counter (Gregorian and Julian).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_date_counter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  date_counter_if bus_g ();
  date_counter_if bus_j ();

  date_counter #(.CAL_SELECT(1'b0), .RESET_YEAR(11'd1970)) dut_g (
    .clk(clk), .rst_n(rst_n), .bus(bus_g)
  );
  date_counter #(.CAL_SELECT(1'b1), .RESET_YEAR(11'd1970)) dut_j (
    .clk(clk), .rst_n(rst_n), .bus(bus_j)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    int         d, m, y;
    logic       adv;
    int         ed, em, ey;
    logic       eerr, eny, eovf;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input int d, input int m, input int y, input logic adv);
    bus_g.load = ld; bus_g.loadDay = 6'(d); bus_g.loadMonth = 4'(m);
    bus_g.loadYear = 11'(y); bus_g.advance = adv;
    bus_j.load = ld; bus_j.loadDay = 6'(d); bus_j.loadMonth = 4'(m);
    bus_j.loadYear = 11'(y); bus_j.advance = adv;
  endtask

  task automatic step(input logic ld, input int d, input int m, input int y, input logic adv);
    @(negedge clk);
    drive(ld, d, m, y, adv);
    @(posedge clk);
    #1;
  endtask

  task automatic check_g(input string name, input int d, input int m, input int y,
                         input logic err, input logic ny, input logic ovf);
    check({name, " date"}, {bus_g.dayOfMonth, bus_g.month, bus_g.year}, {6'(d), 4'(m), 11'(y)});
    check({name, " loadErr"}, int'(bus_g.loadErr), int'(err));
    check({name, " newYear"}, int'(bus_g.newYear), int'(ny));
    check({name, " yearOvf"}, int'(bus_g.yearOvf), int'(ovf));
  endtask

  // Independent Gregorian day-of-year, standing in for the downstream calculator
  function automatic int day_of_year(input int d, input int m, input int y);
    int lens[12];
    int acc;
    lens = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if ((y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0))) lens[1] = 29;
    acc = d;
    for (int i = 1; i < m; i++) acc += lens[i - 1];
    return acc;
  endfunction

  initial begin
    int ny_count;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{1, 28, 2, 2004, 0,  28, 2, 2004, 0, 0, 0};
    vecs[1]  = '{0,  0, 0,    0, 1,  29, 2, 2004, 0, 0, 0};
    vecs[2]  = '{0,  0, 0,    0, 1,   1, 3, 2004, 0, 0, 0};
    vecs[3]  = '{1, 28, 2, 1900, 0,  28, 2, 1900, 0, 0, 0};
    vecs[4]  = '{0,  0, 0,    0, 1,   1, 3, 1900, 0, 0, 0};
    vecs[5]  = '{1, 28, 2, 2000, 0,  28, 2, 2000, 0, 0, 0};
    vecs[6]  = '{0,  0, 0,    0, 1,  29, 2, 2000, 0, 0, 0};
    vecs[7]  = '{1, 31,12, 2009, 0,  31,12, 2009, 0, 0, 0};
    vecs[8]  = '{0,  0, 0,    0, 1,   1, 1, 2010, 0, 1, 0};
    vecs[9]  = '{0,  0, 0,    0, 0,   1, 1, 2010, 0, 0, 0};
    vecs[10] = '{1, 31,12, 2047, 0,  31,12, 2047, 0, 0, 0};
    vecs[11] = '{0,  0, 0,    0, 1,   1, 1,    0, 0, 1, 1};
    vecs[12] = '{0,  0, 0,    0, 0,   1, 1,    0, 0, 0, 0};
    vecs[13] = '{1, 15, 4, 2002, 0,  15, 4, 2002, 0, 0, 0};
    vecs[14] = '{1, 31, 4, 2002, 0,  15, 4, 2002, 1, 0, 0};
    vecs[15] = '{0,  0, 0,    0, 0,  15, 4, 2002, 0, 0, 0};
    vecs[16] = '{1, 29, 2, 2002, 0,  15, 4, 2002, 1, 0, 0};
    vecs[17] = '{1,  0, 5, 2002, 0,  15, 4, 2002, 1, 0, 0};
    vecs[18] = '{1,  1,13, 2002, 0,  15, 4, 2002, 1, 0, 0};
    vecs[19] = '{1, 30,11, 2010, 0,  30,11, 2010, 0, 0, 0};
    vecs[20] = '{1, 24, 3, 2002, 1,  24, 3, 2002, 0, 0, 0};
    vecs[21] = '{0,  0, 0,    0, 1,  25, 3, 2002, 0, 0, 0};
    vecs[22] = '{1, 30, 4, 2002, 0,  30, 4, 2002, 0, 0, 0};
    vecs[23] = '{0,  0, 0,    0, 1,   1, 5, 2002, 0, 0, 0};

    // Reset held for two cycles
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    check_g("reset", 1, 1, 1970, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_g("reset hold", 1, 1, 1970, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].ld, vecs[i].d, vecs[i].m, vecs[i].y, vecs[i].adv);
      check_g($sformatf("vec%0d", i), vecs[i].ed, vecs[i].em, vecs[i].ey,
              vecs[i].eerr, vecs[i].eny, vecs[i].eovf);
    end

    // Gregorian vs Julian on 1900
    step(1, 28, 2, 1900, 0);
    step(0, 0, 0, 0, 1);
    check("greg 1900", {bus_g.dayOfMonth, bus_g.month}, {6'd1, 4'd3});
    check("julian 1900", {bus_j.dayOfMonth, bus_j.month, bus_j.year}, {6'd29, 4'd2, 11'd1900});

    // Reset beats load and a pending year rollover
    step(1, 31, 12, 2009, 0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 24, 3, 2002, 1);
    @(posedge clk);
    #1;
    check_g("rst over load", 1, 1, 1970, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);

    // Full leap year at one day per clock
    step(1, 1, 1, 1996, 0);
    check("doy start", day_of_year(int'(bus_g.dayOfMonth), int'(bus_g.month), int'(bus_g.year)), 1);
    ny_count = 0;
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    for (int k = 1; k <= 366; k++) begin
      @(posedge clk);
      #1;
      if (bus_g.newYear) ny_count++;
      check($sformatf("doy step %0d", k),
            day_of_year(int'(bus_g.dayOfMonth), int'(bus_g.month), int'(bus_g.year)),
            (k == 366) ? 1 : k + 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    check("year end date", {bus_g.dayOfMonth, bus_g.month, bus_g.year}, {6'd1, 4'd1, 11'd1997});
    check("newYear count", ny_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
